// File: rtl/ctrl_rtc_scheduler.sv
// RTC access scheduler: time-slices the shared RTC bus between periodic six-register
// read sweeps and on-demand write jobs, inserting writes only between read jobs.
module ctrl_rtc_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned JOB_CYCLES     = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_req,
    output logic [5:0] do_it_leer,
    output logic       do_it_escribir,
    output logic       wr_ack,
    output logic       sweep_done,
    output logic [1:0] rtc_owner,
    output logic       busy
);

    localparam int unsigned RW       = $clog2(REFRESH_CYCLES + 1);
    localparam int unsigned JW       = $clog2(JOB_CYCLES + 1);
    localparam int unsigned IW       = 3;
    localparam logic [IW-1:0] IDX_LAST = IW'(5);

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_RD   = 2'b01;
    localparam logic [1:0] OWN_WR   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_START = 3'd1,
        RD_WAIT  = 3'd2,
        WR_START = 3'd3,
        WR_WAIT  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [JW-1:0] job_q, job_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic          sweep_pending_q, sweep_pending_d;
    logic          sweep_active_q, sweep_active_d;
    logic          wr_guard_q, wr_guard_d;

    logic [5:0]    leer_q, leer_d;
    logic          escribir_q, escribir_d;
    logic          wr_ack_q, wr_ack_d;
    logic          sweep_done_q, sweep_done_d;
    logic [1:0]    owner_q, owner_d;
    logic          busy_q, busy_d;

    logic          job_last;
    logic          refresh_tc;

    // Next-state, counters and flags
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        job_d           = job_q;
        sweep_pending_d = sweep_pending_q;
        sweep_active_d  = sweep_active_q;
        wr_guard_d      = 1'b0;

        refresh_tc = (refresh_q == RW'(REFRESH_CYCLES - 1));
        refresh_d  = refresh_tc ? '0 : refresh_q + RW'(1);
        job_last   = (job_q == JW'(JOB_CYCLES - 1));

        case (state_q)
            IDLE: begin
                if (wr_req && !wr_guard_q) begin
                    state_d = WR_START;
                end else if (sweep_pending_q && enable) begin
                    state_d         = RD_START;
                    idx_d           = '0;
                    sweep_active_d  = 1'b1;
                    sweep_pending_d = 1'b0;
                end
            end
            RD_START: begin
                job_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                job_d = job_q + JW'(1);
                if (job_last) begin
                    if (idx_q == IDX_LAST) begin
                        sweep_active_d = 1'b0;
                        idx_d          = '0;
                        state_d        = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = wr_req ? WR_START : RD_START;
                    end
                end
            end
            WR_START: begin
                job_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                job_d = job_q + JW'(1);
                if (job_last) begin
                    // Masks a requester that drops wr_req one cycle after the ack
                    wr_guard_d = 1'b1;
                    state_d    = sweep_active_q ? RD_START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A terminal count while a request is already waiting does not queue
        if (refresh_tc) begin
            sweep_pending_d = 1'b1;
        end
    end

    // Output decode from the upcoming state so the ports come straight from flops
    always_comb begin
        leer_d       = (state_d == RD_START) ? (6'(1) << idx_d) : 6'd0;
        escribir_d   = (state_d == WR_START);
        wr_ack_d     = (state_d == WR_WAIT) && (job_d == JW'(JOB_CYCLES - 1));
        sweep_done_d = (state_d == RD_WAIT) && (job_d == JW'(JOB_CYCLES - 1))
                       && (idx_d == IDX_LAST);
        busy_d       = (state_d != IDLE);
        case (state_d)
            RD_START, RD_WAIT: owner_d = OWN_RD;
            WR_START, WR_WAIT: owner_d = OWN_WR;
            default:           owner_d = OWN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            job_q           <= '0;
            refresh_q       <= '0;
            sweep_pending_q <= 1'b0;
            sweep_active_q  <= 1'b0;
            wr_guard_q      <= 1'b0;
            leer_q          <= 6'd0;
            escribir_q      <= 1'b0;
            wr_ack_q        <= 1'b0;
            sweep_done_q    <= 1'b0;
            owner_q         <= OWN_IDLE;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            job_q           <= job_d;
            refresh_q       <= refresh_d;
            sweep_pending_q <= sweep_pending_d;
            sweep_active_q  <= sweep_active_d;
            wr_guard_q      <= wr_guard_d;
            leer_q          <= leer_d;
            escribir_q      <= escribir_d;
            wr_ack_q        <= wr_ack_d;
            sweep_done_q    <= sweep_done_d;
            owner_q         <= owner_d;
            busy_q          <= busy_d;
        end
    end

    assign do_it_leer     = leer_q;
    assign do_it_escribir = escribir_q;
    assign wr_ack         = wr_ack_q;
    assign sweep_done     = sweep_done_q;
    assign rtc_owner      = owner_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_ctrl_rtc_scheduler.sv
// Directed checkpoint table for ctrl_rtc_scheduler (REFRESH_CYCLES=200, JOB_CYCLES=36).
// Cycle 0 is the first rising edge with reset low; outputs are sampled 1 time unit after each edge.
module tb_ctrl_rtc_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       wr_req;
    logic [5:0] do_it_leer;
    logic       do_it_escribir;
    logic       wr_ack;
    logic       sweep_done;
    logic [1:0] rtc_owner;
    logic       busy;

    ctrl_rtc_scheduler #(
        .REFRESH_CYCLES(200),
        .JOB_CYCLES    (36)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .wr_req        (wr_req),
        .do_it_leer    (do_it_leer),
        .do_it_escribir(do_it_escribir),
        .wr_ack        (wr_ack),
        .sweep_done    (sweep_done),
        .rtc_owner     (rtc_owner),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        int         cyc;
        bit         en;
        bit         wr;
        logic [5:0] leer;
        logic       esc;
        logic       ack;
        logic       done;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   tests;
    int   fails;

    function automatic void add(bit rst, int c, bit en, bit wr, logic [5:0] leer,
                                logic esc, logic ack, logic done, logic [1:0] own, logic bsy);
        vec_t v;
        v.rst = rst; v.cyc = c; v.en = en; v.wr = wr; v.leer = leer;
        v.esc = esc; v.ack = ack; v.done = done; v.own = own; v.busy = bsy;
        vecs.push_back(v);
    endfunction

    // One clock; start pulses must never overlap
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tests++;
        if ($countones({do_it_leer, do_it_escribir}) > 1) begin
            fails++;
            $display("FAIL start_onehot cyc=%0d got leer=%b esc=%b, at most one bit allowed",
                     cyc, do_it_leer, do_it_escribir);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        cyc    = 0;
        reset  = 1'b1;
        enable = 1'b0;
        wr_req = 1'b0;

        // Plain sweep: pulses 37 apart, done on last read cycle, pending re-armed during sweep
        add(1,  -1, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0,   0, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 199, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 200, 1, 0, 6'h01, 0, 0, 0, 2'b01, 1);
        add(0, 201, 1, 0, 6'h00, 0, 0, 0, 2'b01, 1);
        add(0, 236, 1, 0, 6'h00, 0, 0, 0, 2'b01, 1);
        add(0, 237, 1, 0, 6'h02, 0, 0, 0, 2'b01, 1);
        add(0, 274, 1, 0, 6'h04, 0, 0, 0, 2'b01, 1);
        add(0, 311, 1, 0, 6'h08, 0, 0, 0, 2'b01, 1);
        add(0, 348, 1, 0, 6'h10, 0, 0, 0, 2'b01, 1);
        add(0, 385, 1, 0, 6'h20, 0, 0, 0, 2'b01, 1);
        add(0, 420, 1, 0, 6'h00, 0, 0, 0, 2'b01, 1);
        add(0, 421, 1, 0, 6'h00, 0, 0, 1, 2'b01, 1);
        add(0, 422, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 423, 1, 0, 6'h01, 0, 0, 0, 2'b01, 1);

        // Write raised during the seg read is inserted before the min read
        add(1,  -1, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 200, 1, 0, 6'h01, 0, 0, 0, 2'b01, 1);
        add(0, 236, 1, 1, 6'h00, 0, 0, 0, 2'b01, 1);
        add(0, 237, 1, 1, 6'h00, 1, 0, 0, 2'b10, 1);
        add(0, 273, 1, 1, 6'h00, 0, 1, 0, 2'b10, 1);
        add(0, 274, 1, 0, 6'h02, 0, 0, 0, 2'b01, 1);
        add(0, 311, 1, 0, 6'h04, 0, 0, 0, 2'b01, 1);
        add(0, 422, 1, 0, 6'h20, 0, 0, 0, 2'b01, 1);
        add(0, 458, 1, 0, 6'h00, 0, 0, 1, 2'b01, 1);
        add(0, 459, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);

        // Write and pending sweep together: write first, late wr_req drop ignored, sweep from seg
        add(1,  -1, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 199, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 200, 1, 1, 6'h00, 1, 0, 0, 2'b10, 1);
        add(0, 236, 1, 1, 6'h00, 0, 1, 0, 2'b10, 1);
        add(0, 237, 1, 1, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 238, 1, 1, 6'h01, 0, 0, 0, 2'b01, 1);
        add(0, 239, 1, 0, 6'h00, 0, 0, 0, 2'b01, 1);
        add(0, 275, 1, 0, 6'h02, 0, 0, 0, 2'b01, 1);
        add(0, 423, 1, 0, 6'h20, 0, 0, 0, 2'b01, 1);
        add(0, 459, 1, 0, 6'h00, 0, 0, 1, 2'b01, 1);
        add(0, 460, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);

        // Reset in the middle of the hora read, then a fresh sweep from seg
        add(1,  -1, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 274, 1, 0, 6'h04, 0, 0, 0, 2'b01, 1);
        add(0, 290, 1, 0, 6'h00, 0, 0, 0, 2'b01, 1);
        add(1,  -1, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 199, 1, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 200, 1, 0, 6'h01, 0, 0, 0, 2'b01, 1);

        // Enable held low across the terminal count; pending survives until enable rises
        add(1,  -1, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 200, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 250, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0, 251, 1, 0, 6'h01, 0, 0, 0, 2'b01, 1);

        // Reset during a write: no ack, held wr_req is served again as a new job
        add(1,  -1, 0, 1, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0,   0, 0, 1, 6'h00, 1, 0, 0, 2'b10, 1);
        add(0,  20, 0, 1, 6'h00, 0, 0, 0, 2'b10, 1);
        add(1,  -1, 0, 1, 6'h00, 0, 0, 0, 2'b00, 0);
        add(0,   0, 0, 1, 6'h00, 1, 0, 0, 2'b10, 1);
        add(0,  35, 0, 1, 6'h00, 0, 0, 0, 2'b10, 1);
        add(0,  36, 0, 1, 6'h00, 0, 1, 0, 2'b10, 1);
        add(0,  37, 0, 0, 6'h00, 0, 0, 0, 2'b00, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            enable = vecs[i].en;
            wr_req = vecs[i].wr;
            if (vecs[i].rst) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                cyc   = -1;
            end
            while (cyc < vecs[i].cyc) step();
            tests++;
            if ({do_it_leer, do_it_escribir, wr_ack, sweep_done, rtc_owner, busy} !==
                {vecs[i].leer, vecs[i].esc, vecs[i].ack, vecs[i].done, vecs[i].own, vecs[i].busy}) begin
                fails++;
                $display("FAIL vec%0d cyc=%0d got leer=%b esc=%b ack=%b done=%b own=%b busy=%b exp leer=%b esc=%b ack=%b done=%b own=%b busy=%b",
                         i, cyc, do_it_leer, do_it_escribir, wr_ack, sweep_done, rtc_owner, busy,
                         vecs[i].leer, vecs[i].esc, vecs[i].ack, vecs[i].done, vecs[i].own, vecs[i].busy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_rtc_scheduler.md
CTRL_RTC_SCHEDULER -- requirements
Module: ctrl_rtc_scheduler

Interface
REQ-001 Parameter REFRESH_CYCLES, default 100000: clock cycles between periodic read-sweep requests.
REQ-002 Parameter JOB_CYCLES, default 36: cycles granted to one RTC job after its start pulse; SHALL exceed the per-register read/write FSM run length (35 cycles).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = periodic read sweeps allowed; 0 = no new sweep starts.
REQ-006 wr_req  input  1  level write request from the edit path; held until wr_ack.
REQ-007 do_it_leer  output  6  one-hot start pulse to the read FSMs: bit0 seg, bit1 min, bit2 hora, bit3 dia, bit4 mes, bit5 anio.
REQ-008 do_it_escribir  output  1  one-cycle start pulse to the RTC write FSM.
REQ-009 wr_ack  output  1  one-cycle pulse when a write job completes.
REQ-010 sweep_done  output  1  one-cycle pulse when all six reads of a sweep complete.
REQ-011 rtc_owner  output  2  shared RTC bus select (a_d/cs/rd/wr mux): 00 idle, 01 read FSMs, 10 write FSM.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, RD_START, RD_WAIT, WR_START and WR_WAIT; all outputs SHALL be Moore-decoded from the registered state and flags.
REQ-014 Refresh counter SHALL count 0..REFRESH_CYCLES-1 and wrap, free-running in all states; at terminal count it SHALL set sweep_pending (set while already set = no change, no queueing).
REQ-015 IDLE: wr_req=1 (and wr guard clear) -> WR_START; else sweep_pending=1 and enable=1 -> RD_START with idx=0, sweep_active=1, sweep_pending cleared; else stay.
REQ-016 Simultaneous wr_req and sweep_pending in IDLE: write SHALL win; sweep_pending SHALL be retained.
REQ-017 RD_START lasts exactly 1 cycle: do_it_leer[idx]=1, job counter cleared -> RD_WAIT.
REQ-018 RD_WAIT: job counter increments each cycle; exit when count == JOB_CYCLES-1.
REQ-019 At that exit: idx==5 -> sweep_done=1 for 1 cycle, sweep_active=0, idx=0, go to IDLE; else idx+1 and go to WR_START if wr_req=1, otherwise RD_START.
REQ-020 WR_START lasts 1 cycle: do_it_escribir=1, job counter cleared -> WR_WAIT.
REQ-021 WR_WAIT: exit at count == JOB_CYCLES-1 with wr_ack=1 for 1 cycle; next state RD_START (saved idx) if sweep_active, else IDLE.
REQ-022 The cycle after wr_ack SHALL ignore wr_req (guard flag), so a requester dropping wr_req one cycle late does not start a second write.
REQ-023 A write SHALL never preempt a running read job; it is inserted only between read jobs.
REQ-024 Consecutive start pulses SHALL be exactly JOB_CYCLES+1 cycles apart when no write intervenes.
REQ-025 enable=0 SHALL NOT abort a sweep in progress; it only blocks the IDLE->RD_START transition.
REQ-026 rtc_owner SHALL be 01 in RD_START/RD_WAIT, 10 in WR_START/WR_WAIT, and 00 in IDLE.
REQ-027 At most one bit of {do_it_leer, do_it_escribir} SHALL be high in any cycle.
REQ-028 Latency: sweep_pending set at cycle T with IDLE and enable=1 -> do_it_leer=000001 at T+1.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, idx=0, job and refresh counters 0, and sweep_pending, sweep_active and the wr guard all 0.
REQ-030 During and after reset, all outputs SHALL be 0 until new activity: do_it_leer=000000, do_it_escribir=0, wr_ack=0, sweep_done=0, rtc_owner=00, busy=0.
REQ-031 Reset mid-job SHALL abort the job with no wr_ack or sweep_done; a pending wr_req SHALL be re-served as new after reset.

Verification (REFRESH_CYCLES=200, JOB_CYCLES=36)
REQ-032 Reset release, enable=1, no wr_req -> first do_it_leer=000001 at cycle 200; then 000010, 000100 ... 100000 at 37-cycle spacing; sweep_done at cycle 200+6*37-1; then back to IDLE.
REQ-033 wr_req raised during the seg read -> do_it_escribir 37 cycles after the seg pulse; wr_ack 36 cycles later; min read pulse on the next cycle; sweep completes with all six bits.
REQ-034 wr_req and sweep_pending both true in IDLE -> write first (rtc_owner=10), then sweep from idx 0; wr_ack exactly once.
REQ-035 wr_req held 1 cycle after wr_ack -> no second do_it_escribir.
REQ-036 reset pulsed in mid RD_WAIT of hora -> next cycle all outputs 0, busy=0; next sweep starts at bit0 after 200 cycles.
REQ-037 enable=0 across a refresh terminal count -> no pulse; enable raised later -> do_it_leer=000001 one cycle later (pending retained).
